// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode constants, FSM state encodings and a parity helper.
// ST_BREAK exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
        ,
        ST_BREAK  = 3'd5
`endif
    } uart_state_t;

    // Payload is zero-extended to 9 bits, so the XOR is unaffected by DATA_BITS.
    function automatic logic calc_parity(input logic [8:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_end strobes on the last cycle of each CLKS_PER_BIT-cycle period.
// The load input holds the count at zero so the next period starts on the cycle after load drops.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic load,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign bit_end = !load && (cnt_reg == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_reg <= '0;
        end else if (load || bit_end) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS LSB first, optional parity, STOP_BITS stops.
// Define UART_TX_BREAK_EN to add the i_break input and the BREAK line condition.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 27000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1
) (
`ifdef UART_TX_BREAK_EN
    input  logic                 i_break,
`endif
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_BITS-1:0] data_send,
    input  logic                 tx_valid,
    output logic                 ready_tx,
    output logic                 o_tx,
    output logic                 tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int IDX_W        = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_t          state_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_reg;
    logic [IDX_W-1:0]     bit_idx_reg;
    logic                 stop_idx_reg;
    logic                 tx_reg;
    logic                 ready_reg;
    logic                 done_reg;
    logic                 baud_load;
    logic                 bit_end;
`ifdef UART_TX_BREAK_EN
    logic                 brk_stop_reg;
`endif

    assign o_tx     = tx_reg;
    assign ready_tx = ready_reg;
    assign tx_done  = done_reg;

    // The bit timer is parked while nothing is being timed, so every period is full length.
`ifdef UART_TX_BREAK_EN
    assign baud_load = (state_reg == ST_IDLE) || (state_reg == ST_BREAK);
`else
    assign baud_load = (state_reg == ST_IDLE);
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .load   (baud_load),
        .bit_end(bit_end)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            tx_reg       <= 1'b1;
            ready_reg    <= 1'b1;
            done_reg     <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_stop_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
`ifdef UART_TX_BREAK_EN
                    if (i_break) begin
                        state_reg <= ST_BREAK;
                        tx_reg    <= 1'b0;
                        ready_reg <= 1'b0;
                    end else
`endif
                    if (ready_reg && tx_valid) begin
                        shift_reg    <= data_send;
                        parity_reg   <= calc_parity(9'(data_send), PARITY_MODE);
                        bit_idx_reg  <= '0;
                        stop_idx_reg <= 1'b0;
                        state_reg    <= ST_START;
                        tx_reg       <= 1'b0;
                        ready_reg    <= 1'b0;
`ifdef UART_TX_BREAK_EN
                        brk_stop_reg <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_reg <= ST_DATA;
                        tx_reg    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_reg == IDX_LAST) begin
                            if (PARITY_MODE != PARITY_NONE) begin
                                state_reg <= ST_PARITY;
                                tx_reg    <= parity_reg;
                            end else begin
                                state_reg    <= ST_STOP;
                                tx_reg       <= 1'b1;
                                stop_idx_reg <= 1'b0;
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_reg    <= ST_STOP;
                        tx_reg       <= 1'b1;
                        stop_idx_reg <= 1'b0;
                    end
                end
                ST_STOP: begin
                    tx_reg <= 1'b1;
                    if (bit_end) begin
                        if (stop_idx_reg == STOP_LAST) begin
                            state_reg <= ST_IDLE;
                            ready_reg <= 1'b1;
`ifdef UART_TX_BREAK_EN
                            done_reg  <= !brk_stop_reg;
`else
                            done_reg  <= 1'b1;
`endif
                        end else begin
                            stop_idx_reg <= stop_idx_reg + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                // Break release reuses the stop sequence but must not report a frame.
                ST_BREAK: begin
                    tx_reg <= 1'b0;
                    if (!i_break) begin
                        state_reg    <= ST_STOP;
                        tx_reg       <= 1'b1;
                        stop_idx_reg <= 1'b0;
                        brk_stop_reg <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_reg <= ST_IDLE;
                    tx_reg    <= 1'b1;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: a default instance and a 7-bit/odd/2-stop instance checked against
// a frame-level line model every cycle, plus directed frames with hand-computed expectations.
module tb_uart_tx_param;

    typedef struct packed {
        bit         busy;
        bit         brk;
        bit         brk_stop;
        int         t;
        logic [8:0] data;
        bit         tx;
        bit         ready;
        bit         done;
    } mdl_t;

    localparam int CPB_A = 27000000 / 115200;
    localparam int CPB_B = 1600 / 100;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic [7:0] data_a = '0;
    logic [6:0] data_b = '0;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic       brk_a = 1'b0, brk_b = 1'b0;
    logic       a_tx, a_ready, a_done;
    logic       b_tx, b_ready, b_done;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   chk_a   = 0, chk_b = 0;
    mdl_t ma = '0, mb = '0;

    always #5 clk = ~clk;

    uart_tx_param u_a (
`ifdef UART_TX_BREAK_EN
        .i_break  (brk_a),
`endif
        .i_clk    (clk),
        .i_rst    (rst_a),
        .data_send(data_a),
        .tx_valid (valid_a),
        .ready_tx (a_ready),
        .o_tx     (a_tx),
        .tx_done  (a_done)
    );

    uart_tx_param #(
        .CLK_FREQ_HZ(1600),
        .BAUD_RATE  (100),
        .DATA_BITS  (7),
        .PARITY_MODE(2),
        .STOP_BITS  (2)
    ) u_b (
`ifdef UART_TX_BREAK_EN
        .i_break  (brk_b),
`endif
        .i_clk    (clk),
        .i_rst    (rst_b),
        .data_send(data_b),
        .tx_valid (valid_b),
        .ready_tx (b_ready),
        .o_tx     (b_tx),
        .tx_done  (b_done)
    );

    // Line level t cycles after acceptance: bit slot t/cpb of start, data, parity, stops.
    function automatic bit line_bit(int cpb, int db, int pm, logic [8:0] d, int t);
        int b;
        bit p;
        b = t / cpb;
        p = 0;
        for (int i = 0; i < db; i++) p = p ^ d[i];
        if (pm == 2) p = ~p;
        if (b == 0) return 1'b0;
        if (b <= db) return d[b-1];
        if (pm != 0 && b == db + 1) return p;
        return 1'b1;
    endfunction

    function automatic mdl_t model_step(mdl_t m, int cpb, int db, int pm, int sb,
                                        bit rst, bit valid, logic [8:0] d, bit brk);
        mdl_t n;
        int   flen;
        n = m;
        n.done = 0;
        flen = (1 + db + ((pm != 0) ? 1 : 0) + sb) * cpb;
        if (rst) begin
            n = '0;
            n.tx = 1;
            n.ready = 1;
        end else if (m.brk) begin
            if (!brk) begin
                n.brk = 0; n.brk_stop = 1; n.t = 0; n.tx = 1;
            end
        end else if (m.brk_stop) begin
            n.t = m.t + 1;
            if (n.t == sb * cpb) begin
                n.brk_stop = 0; n.ready = 1;
            end
        end else if (m.busy) begin
            n.t = m.t + 1;
            if (n.t == flen) begin
                n.busy = 0; n.ready = 1; n.done = 1; n.tx = 1;
            end else begin
                n.tx = line_bit(cpb, db, pm, m.data, n.t);
            end
        end else if (brk) begin
            n.brk = 1; n.tx = 0; n.ready = 0;
        end else if (valid) begin
            n.busy = 1; n.t = 0; n.data = d; n.tx = 0; n.ready = 0;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        ma = model_step(ma, CPB_A, 8, 1, 1, rst_a, valid_a, 9'(data_a), brk_a);
        mb = model_step(mb, CPB_B, 7, 2, 2, rst_b, valid_b, 9'(data_b), brk_b);
    end

    // Every-cycle comparison of all three outputs of both instances against the model.
    initial forever begin
        @(negedge clk);
        if (chk_a) begin
            n_tests++;
            if ({a_tx, a_ready, a_done} !== {ma.tx, ma.ready, ma.done}) begin
                n_fail++;
                if (n_fail < 30)
                    $display("FAIL cmp_a: tx/ready/done got %b%b%b expected %b%b%b at cycle %0d",
                             a_tx, a_ready, a_done, ma.tx, ma.ready, ma.done, cyc);
            end
        end
        if (chk_b) begin
            n_tests++;
            if ({b_tx, b_ready, b_done} !== {mb.tx, mb.ready, mb.done}) begin
                n_fail++;
                if (n_fail < 30)
                    $display("FAIL cmp_b: tx/ready/done got %b%b%b expected %b%b%b at cycle %0d",
                             b_tx, b_ready, b_done, mb.tx, mb.ready, mb.done, cyc);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 300000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic stim_a();
        logic [10:0] a5_bits;
        logic [7:0]  pay [3];
        int          done_at, nacc, ndone, last_done, hi, j, gap;
        a5_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
        repeat (3) @(negedge clk);
        rst_a = 0;
        chk_a = 1;
        check("a_rst_tx", a_tx, 1);
        check("a_rst_ready", a_ready, 1);
        check("a_rst_done", a_done, 0);

        // Directed 0xA5 frame; data_send is scrambled every cycle after acceptance.
        data_a = 8'hA5; valid_a = 1;
        @(negedge clk);
        valid_a = 0;
        done_at = -1;
        for (int i = 0; i < 3000; i++) begin
            data_a = 8'($urandom);
            if (i == 0 || i == 233) check("a5_start_low", a_tx, 0);
            if (i % CPB_A == CPB_A / 2 && i / CPB_A < 11) check("a5_bit", a_tx, 32'(a5_bits[i / CPB_A]));
            if (a_done) begin done_at = i; break; end
            @(negedge clk);
        end
        check("a5_done_cycle", done_at, 2574);
        $display("[A] frame 0xA5 done %0d cycles after acceptance", done_at);

        // Three back-to-back payloads with tx_valid held high.
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) pay[k] = 8'($urandom);
        valid_a = 1; nacc = 0; ndone = 0; last_done = 0;
        for (int i = 0; i < 9000 && ndone < 3; i++) begin
            if (a_ready && nacc < 3) begin
                data_a = pay[nacc];
                nacc++;
            end else begin
                data_a = 8'($urandom);
                if (nacc == 3) valid_a = 0;
            end
            if (a_done) begin
                if (ndone > 0) check("b2b_done_period", i - last_done, 2575);
                last_done = i;
                ndone++;
                $display("[A] back-to-back frame %0d done at cycle %0d", ndone, cyc);
            end
            @(negedge clk);
        end
        valid_a = 0;
        check("b2b_frames", ndone, 3);

        // Reset pulse in the middle of data bit 2, with tx_valid high during reset.
        repeat (3) @(negedge clk);
        data_a = 8'($urandom); valid_a = 1;
        @(negedge clk);
        valid_a = 0;
        repeat (CPB_A * 3 + 100) @(negedge clk);
        rst_a = 1; valid_a = 1;
        @(negedge clk);
        rst_a = 0; valid_a = 0;
        check("rst_mid_tx", a_tx, 1);
        check("rst_mid_ready", a_ready, 1);
        check("rst_mid_done", a_done, 0);
        repeat (50) @(negedge clk);
        check("rst_mid_idle_tx", a_tx, 1);
        $display("[A] mid-frame reset at cycle %0d", cyc);

        // Random frames, with stray tx_valid pulses while busy.
        for (int f = 0; f < 4; f++) begin
            gap = $urandom_range(0, 20);
            repeat (gap) @(negedge clk);
            data_a = 8'($urandom); valid_a = 1;
            @(negedge clk);
            done_at = -1;
            for (int i = 0; i < 3000; i++) begin
                valid_a = a_ready ? 1'b0 : ($urandom_range(0, 30) == 0);
                data_a = 8'($urandom);
                if (a_done) begin done_at = i; break; end
                @(negedge clk);
            end
            valid_a = 0;
            check("a_rand_done_cycle", done_at, 2574);
            $display("[A] random frame %0d done %0d cycles after acceptance", f, done_at);
        end

`ifdef UART_TX_BREAK_EN
        // Break and tx_valid together for 5000 cycles: break wins, payload is dropped.
        repeat (5) @(negedge clk);
        brk_a = 1; valid_a = 1; data_a = 8'($urandom);
        hi = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (a_tx == 1'b0 && a_ready == 1'b0) hi++;
        end
        check("brk_low_cycles", hi, 5000);
        brk_a = 0; valid_a = 0;
        hi = 0; j = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (a_ready) begin j = i; break; end
            if (a_tx) hi++;
        end
        check("brk_stop_cycles", hi, CPB_A);
        check("brk_ready_at", j, CPB_A + 1);
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_tx == 1'b0 || a_done) hi++;
        end
        check("brk_no_payload", hi, 0);
        $display("[A] break released, line idle at cycle %0d", cyc);
`endif
    endtask

    task automatic stim_b();
        logic [10:0] b3_bits;
        int          done_at, gap, rst_at, w;
        bit          inj, got;
        b3_bits = {1'b1, 1'b1, 1'b1, 7'h03, 1'b0};
        repeat (3) @(negedge clk);
        rst_b = 0;
        chk_b = 1;
        check("b_rst_tx", b_tx, 1);
        check("b_rst_ready", b_ready, 1);

        // Directed 7'h03, odd parity, two stops.
        data_b = 7'h03; valid_b = 1;
        @(negedge clk);
        valid_b = 0;
        done_at = -1;
        for (int i = 0; i < 400; i++) begin
            data_b = 7'($urandom);
            if (i % CPB_B == CPB_B / 2 && i / CPB_B < 11) check("b03_bit", b_tx, 32'(b3_bits[i / CPB_B]));
            if (a_done === 1'bx) check("a_done_known", 0, 1);
            if (b_done) begin done_at = i; break; end
            @(negedge clk);
        end
        check("b03_done_cycle", done_at, 11 * CPB_B);
        $display("[B] frame 0x03 done %0d cycles after acceptance", done_at);

        for (int f = 0; f < 40; f++) begin
            gap = $urandom_range(0, 12);
            inj = ($urandom_range(0, 7) == 0);
            rst_at = $urandom_range(1, 170);
            repeat (gap) @(negedge clk);
            w = 0;
            while (!b_ready && w < 400) begin @(negedge clk); w++; end
            data_b = 7'($urandom); valid_b = 1;
            @(negedge clk);
            valid_b = 0;
            got = 0;
            for (int i = 0; i < 400; i++) begin
                data_b = 7'($urandom);
                valid_b = b_ready ? 1'b0 : ($urandom_range(0, 20) == 0);
                rst_b = inj && (i == rst_at);
                if (b_done) begin got = 1; break; end
                if (inj && i > rst_at) break;
                @(negedge clk);
            end
            rst_b = 0; valid_b = 0;
            if (!inj) check("b_frame_done", 32'(got), 1);
            $display("[B] random frame %0d %s at cycle %0d", f, inj ? "reset" : "done", cyc);
        end
    endtask

    initial begin
        fork
            stim_a();
            stim_b();
        join
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 27000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning serial bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..9, meaning payload bits per frame.
REQ-004 SHALL have parameter PARITY_MODE, default 1, meaning 0=none, 1=even, 2=odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1..2, meaning number of stop bit periods.
REQ-006 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port data_send, input, DATA_BITS, payload to transmit.
REQ-009 SHALL have port tx_valid, input, 1, payload valid request.
REQ-010 SHALL have port ready_tx, output, 1, block idle and able to accept a payload.
REQ-011 SHALL have port o_tx, output, 1, registered serial line, idle high.
REQ-012 SHALL have port tx_done, output, 1, one-cycle pulse at frame end.

Function
REQ-013 SHALL use CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE, truncated, with a counter of $clog2(CLKS_PER_BIT) bits; every line bit lasts exactly CLKS_PER_BIT cycles.
REQ-014 SHALL accept a payload only in a cycle with ready_tx=1 and tx_valid=1, latching data_send and its parity in that cycle.
REQ-015 SHALL deassert ready_tx in the cycle after acceptance and hold it low until the frame ends; tx_valid is ignored and not queued while ready_tx=0.
REQ-016 SHALL ignore changes on data_send after acceptance.
REQ-017 SHALL use states IDLE -> START -> DATA -> PARITY (skipped when PARITY_MODE=0) -> STOP -> IDLE.
REQ-018 SHALL drive the start bit low from the cycle after acceptance, data LSB first, then parity, then STOP_BITS high periods.
REQ-019 SHALL compute parity as XOR of payload for even mode and its inverse for odd mode.
REQ-020 SHALL give a frame length of (1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-021 SHALL pulse tx_done and raise ready_tx in the cycle after the last stop cycle.
REQ-022 SHALL start the next start bit without an idle gap when tx_valid=1 in the first cycle ready_tx is high again.
REQ-023 SHALL treat an undefined state encoding as IDLE with o_tx=1.

Reset
REQ-024 SHALL, on i_rst=1 at a clock edge, force state IDLE, counters 0, o_tx=1, ready_tx=1, tx_done=0, aborting any frame mid-bit.
REQ-025 SHALL, in the cycle i_rst=1, not accept a payload even if tx_valid=1.

Configuration
REQ-026 SHALL, with macro UART_TX_BREAK_EN defined, add input i_break (1 bit) and state BREAK.
REQ-027 SHALL, with UART_TX_BREAK_EN defined, enter BREAK from IDLE when i_break=1, drive o_tx low and ready_tx low, and take priority over a simultaneous tx_valid.
REQ-028 SHALL, with UART_TX_BREAK_EN defined, ignore i_break during a frame until IDLE.
REQ-029 SHALL, with UART_TX_BREAK_EN defined, after i_break falls, drive STOP_BITS high periods, then return to IDLE without a tx_done pulse.
REQ-030 SHALL, without UART_TX_BREAK_EN, have no i_break port and no BREAK state, with all other behaviour identical.

Structure
REQ-031 SHALL place parity-mode constants (PARITY_NONE/EVEN/ODD) and the state encodings in shared package uart_pkg, also used by the receiver.
REQ-032 SHALL implement bit-period timing in sub-module uart_baud_gen, which emits a one-cycle bit_end strobe, restarts on a load input, and is parameterised by CLKS_PER_BIT.

Verification
REQ-033 SHALL verify: defaults, data_send=8'hA5, one-cycle tx_valid -> o_tx low 234 cycles, then bits 1,0,1,0,0,1,0,1, parity 0, 1 stop; tx_done at cycle 2574 after acceptance.
REQ-034 SHALL verify: PARITY_MODE=2, DATA_BITS=7, STOP_BITS=2, payload 7'h03 -> parity bit 1, two stop periods, frame 11*CLKS_PER_BIT cycles.
REQ-035 SHALL verify: tx_valid held high for three payloads -> three back-to-back frames, no idle cycles between them, data_send changes mid-frame ignored.
REQ-036 SHALL verify: i_rst pulsed mid-data-bit -> next cycle o_tx=1, ready_tx=1, no tx_done; following frame correct.
REQ-037 SHALL verify: with UART_TX_BREAK_EN, i_break and tx_valid high together in IDLE for 5000 cycles -> o_tx low 5000 cycles, then STOP_BITS high periods, ready_tx=1, payload not sent.
